// File: rtl/sysbus_txn_arbiter_if.sv
// Request/response bundle shared by the fetch client, the data client and the system bus.
// The master drives the request and accepts responses; the slave accepts requests and returns responses.
interface sysbus_txn_arbiter_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
) ();
  logic [BUS_DATA_WIDTH-1:0] req;
  logic                      reqcyc;
  logic [BUS_TAG_WIDTH-1:0]  reqtag;
  logic                      reqack;
  logic [BUS_DATA_WIDTH-1:0] resp;
  logic                      respcyc;
  logic [BUS_TAG_WIDTH-1:0]  resptag;
  logic                      respack;

  modport master (
    output req, reqcyc, reqtag, respack,
    input  reqack, resp, respcyc, resptag
  );

  modport slave (
    input  req, reqcyc, reqtag, respack,
    output reqack, resp, respcyc, resptag
  );
endinterface

// File: rtl/sysbus_txn_arbiter.sv
// Round-robin arbiter that shares one system bus between a fetch client (ibus) and a data client (dbus).
// A grant covers one request phase and, for reads, RESP_BEATS acknowledged response beats.
module sysbus_txn_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int RESP_BEATS     = 8,
  parameter int WR_TAG_BIT     = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  sysbus_txn_arbiter_if.slave         ibus,
  sysbus_txn_arbiter_if.slave         dbus,
  sysbus_txn_arbiter_if.master        bus,
  output logic [1:0]                  owner
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_IBUS  = 2'b01;
  localparam logic [1:0] OWN_DBUS  = 2'b10;
  localparam logic [7:0] LAST_BEAT = 8'(RESP_BEATS - 1);

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic       is_write_q, is_write_d;
  logic       last_dbus_q, last_dbus_d;
  logic [7:0] cnt_q, cnt_d;

  logic                      own_ibus;
  logic [BUS_DATA_WIDTH-1:0] sel_req;
  logic                      sel_reqcyc;
  logic [BUS_TAG_WIDTH-1:0]  sel_reqtag;
  logic                      sel_respack;

  // The current owner's request and response-accept lines, selected once for reuse below.
  assign own_ibus    = (owner_q == OWN_IBUS);
  assign sel_req     = own_ibus ? ibus.req     : dbus.req;
  assign sel_reqcyc  = own_ibus ? ibus.reqcyc  : dbus.reqcyc;
  assign sel_reqtag  = own_ibus ? ibus.reqtag  : dbus.reqtag;
  assign sel_respack = own_ibus ? ibus.respack : dbus.respack;
  assign owner       = owner_q;

  // State register; reset drops any grant in flight and lets ibus win the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      is_write_q  <= 1'b0;
      last_dbus_q <= 1'b1;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      is_write_q  <= is_write_d;
      last_dbus_q <= last_dbus_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic and the combinational routing of the granted client onto the bus.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    is_write_d   = is_write_q;
    last_dbus_d  = last_dbus_q;
    cnt_d        = cnt_q;
    bus.req      = '0;
    bus.reqcyc   = 1'b0;
    bus.reqtag   = '0;
    bus.respack  = 1'b0;
    ibus.reqack  = 1'b0;
    ibus.respcyc = 1'b0;
    ibus.resp    = '0;
    ibus.resptag = '0;
    dbus.reqack  = 1'b0;
    dbus.respcyc = 1'b0;
    dbus.resp    = '0;
    dbus.resptag = '0;

    case (state_q)
      ST_IDLE: begin
        if (ibus.reqcyc || dbus.reqcyc) begin
          // ibus takes the grant when alone or when dbus had the previous one.
          if (ibus.reqcyc && (!dbus.reqcyc || last_dbus_q)) begin
            owner_d     = OWN_IBUS;
            last_dbus_d = 1'b0;
            is_write_d  = ibus.reqtag[WR_TAG_BIT];
          end else begin
            owner_d     = OWN_DBUS;
            last_dbus_d = 1'b1;
            is_write_d  = dbus.reqtag[WR_TAG_BIT];
          end
          state_d = ST_REQ;
          cnt_d   = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        bus.req    = sel_req;
        bus.reqcyc = sel_reqcyc;
        bus.reqtag = sel_reqtag;
        if (own_ibus) begin
          ibus.reqack = bus.reqack;
        end else begin
          dbus.reqack = bus.reqack;
        end
        if (!sel_reqcyc) begin
          if (is_write_q) begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
          end else begin
            state_d = ST_RESP;
            cnt_d   = 8'd0;
          end
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_RESP: begin
        bus.respack = sel_respack;
        if (own_ibus) begin
          ibus.respcyc = bus.respcyc;
          ibus.resp    = bus.resp;
          ibus.resptag = bus.resptag;
        end else begin
          dbus.respcyc = bus.respcyc;
          dbus.resp    = bus.resp;
          dbus.resptag = bus.resptag;
        end
        if (bus.respcyc && sel_respack) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        cnt_d   = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_sysbus_txn_arbiter.sv
// Randomized and directed stimulus for sysbus_txn_arbiter, checked every cycle against a
// transaction-level model of grant ownership, request forwarding and remaining response beats.
module tb_sysbus_txn_arbiter;
  localparam int DW    = 64;
  localparam int TW    = 13;
  localparam int BEATS = 8;
  localparam int WRB   = 12;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] owner;

  sysbus_txn_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) ibus_if ();
  sysbus_txn_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) dbus_if ();
  sysbus_txn_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bus_if ();

  sysbus_txn_arbiter #(
    .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .RESP_BEATS(BEATS), .WR_TAG_BIT(WRB)
  ) dut (
    .clk(clk), .reset(reset), .ibus(ibus_if), .dbus(dbus_if), .bus(bus_if), .owner(owner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: which client holds the bus (0 none, 1 ibus, 2 dbus), what it is doing, beats still owed.
  int m_owner;
  int m_phase;        // 0 free, 1 forwarding request, 2 returning read data
  bit m_write;
  bit m_dbus_went_last;
  int m_beats_left;
  int ibus_beats_seen;
  int dbus_beats_seen;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_phase = 0; m_write = 1'b0; m_dbus_went_last = 1'b1; m_beats_left = 0;
  endtask

  task automatic set_idle_inputs();
    ibus_if.req = '0; ibus_if.reqcyc = 1'b0; ibus_if.reqtag = '0; ibus_if.respack = 1'b0;
    dbus_if.req = '0; dbus_if.reqcyc = 1'b0; dbus_if.reqtag = '0; dbus_if.respack = 1'b0;
    bus_if.reqack = 1'b0; bus_if.resp = '0; bus_if.respcyc = 1'b0; bus_if.resptag = '0;
  endtask

  task automatic check_outputs();
    logic [1:0]    e_own;
    logic          e_bcyc, e_brespack, e_iack, e_dack, e_icyc, e_dcyc;
    logic [DW-1:0] e_breq, e_iresp, e_dresp;
    logic [TW-1:0] e_btag, e_itag, e_dtag;
    e_own = 2'b00; e_bcyc = 1'b0; e_brespack = 1'b0; e_iack = 1'b0; e_dack = 1'b0;
    e_icyc = 1'b0; e_dcyc = 1'b0; e_breq = '0; e_iresp = '0; e_dresp = '0;
    e_btag = '0; e_itag = '0; e_dtag = '0;
    if (reset) begin
      e_own = 2'(m_owner);
      if (m_phase == 1 && m_owner == 1) begin
        e_bcyc = ibus_if.reqcyc; e_breq = ibus_if.req; e_btag = ibus_if.reqtag; e_iack = bus_if.reqack;
      end else if (m_phase == 1) begin
        e_bcyc = dbus_if.reqcyc; e_breq = dbus_if.req; e_btag = dbus_if.reqtag; e_dack = bus_if.reqack;
      end else if (m_phase == 2 && m_owner == 1) begin
        e_brespack = ibus_if.respack; e_icyc = bus_if.respcyc; e_iresp = bus_if.resp; e_itag = bus_if.resptag;
      end else if (m_phase == 2) begin
        e_brespack = dbus_if.respack; e_dcyc = bus_if.respcyc; e_dresp = bus_if.resp; e_dtag = bus_if.resptag;
      end
    end
    check_val("owner",        64'(owner),           64'(e_own));
    check_val("bus_reqcyc",   64'(bus_if.reqcyc),   64'(e_bcyc));
    check_val("bus_req",      64'(bus_if.req),      64'(e_breq));
    check_val("bus_reqtag",   64'(bus_if.reqtag),   64'(e_btag));
    check_val("bus_respack",  64'(bus_if.respack),  64'(e_brespack));
    check_val("ibus_reqack",  64'(ibus_if.reqack),  64'(e_iack));
    check_val("dbus_reqack",  64'(dbus_if.reqack),  64'(e_dack));
    check_val("ibus_respcyc", 64'(ibus_if.respcyc), 64'(e_icyc));
    check_val("dbus_respcyc", 64'(dbus_if.respcyc), 64'(e_dcyc));
    check_val("ibus_resp",    64'(ibus_if.resp),    64'(e_iresp));
    check_val("ibus_resptag", 64'(ibus_if.resptag), 64'(e_itag));
    check_val("dbus_resp",    64'(dbus_if.resp),    64'(e_dresp));
    check_val("dbus_resptag", 64'(dbus_if.resptag), 64'(e_dtag));
    if (ibus_if.respcyc && ibus_if.respack) ibus_beats_seen++;
    if (dbus_if.respcyc && dbus_if.respack) dbus_beats_seen++;
  endtask

  // Applies the protocol rules to the inputs present at this clock edge.
  task automatic model_advance();
    bit o_cyc, o_ack;
    o_cyc = (m_owner == 1) ? ibus_if.reqcyc  : dbus_if.reqcyc;
    o_ack = (m_owner == 1) ? ibus_if.respack : dbus_if.respack;
    if (!reset) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (ibus_if.reqcyc || dbus_if.reqcyc) begin
        if (ibus_if.reqcyc && (!dbus_if.reqcyc || m_dbus_went_last)) begin
          m_owner = 1; m_write = ibus_if.reqtag[WRB];
        end else begin
          m_owner = 2; m_write = dbus_if.reqtag[WRB];
        end
        m_dbus_went_last = (m_owner == 2);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (!o_cyc && m_write) begin
        m_phase = 0; m_owner = 0;
      end else if (!o_cyc) begin
        m_phase = 2; m_beats_left = BEATS;
      end
    end else begin
      if (bus_if.respcyc && o_ack) begin
        m_beats_left--;
        if (m_beats_left == 0) begin
          m_phase = 0; m_owner = 0;
        end
      end
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    #1;
    check_outputs();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic rand_resp();
    bus_if.resp    = {$urandom, $urandom};
    bus_if.resptag = 13'($urandom);
  endtask

  task automatic acked_beats(input int n);
    bus_if.respcyc = 1'b1; ibus_if.respack = 1'b1; dbus_if.respack = 1'b1;
    for (int b = 0; b < n; b++) begin
      rand_resp();
      run_cycle();
    end
    bus_if.respcyc = 1'b0;
  endtask

  initial begin
    int k;
    set_idle_inputs();
    model_reset();
    ibus_if.reqcyc = 1'b1; dbus_if.reqcyc = 1'b1; bus_if.respcyc = 1'b1; bus_if.reqack = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) run_cycle();
    check_val("reset_owner", 64'(owner), 64'(2'b00));

    // Simultaneous requests out of reset: ibus first, then dbus.
    reset = 1'b1;
    set_idle_inputs();
    ibus_if.reqcyc = 1'b1; ibus_if.reqtag = 13'h0123; ibus_if.req = 64'h1111_2222_3333_4444;
    dbus_if.reqcyc = 1'b1; dbus_if.reqtag = 13'h0456; dbus_if.req = 64'h5555_6666_7777_8888;
    bus_if.reqack = 1'b1;
    run_cycle();
    check_val("tie_ibus_first", 64'(owner), 64'(2'b01));
    #1;
    check_val("grant_latency", 64'(bus_if.reqcyc), 64'(1'b1));
    run_cycle();
    ibus_if.reqcyc = 1'b0;
    run_cycle();
    ibus_beats_seen = 0;
    acked_beats(BEATS);
    check_val("ibus_beats", 64'(ibus_beats_seen), 64'(BEATS));
    check_val("read_done_owner", 64'(owner), 64'(2'b00));
    bus_if.respcyc = 1'b1;
    #1;
    check_val("stray_resp_cyc", 64'(ibus_if.respcyc | dbus_if.respcyc), 64'(1'b0));
    check_val("stray_resp_ack", 64'(bus_if.respack), 64'(1'b0));
    run_cycle();
    check_val("rr_dbus_next", 64'(owner), 64'(2'b10));

    // Alternating response accept: only acked beats count.
    dbus_if.reqcyc = 1'b0;
    bus_if.respcyc = 1'b0;
    run_cycle();
    dbus_beats_seen = 0;
    k = 0;
    while (m_phase != 0 && k < 40) begin
      bus_if.respcyc = 1'b1; dbus_if.respack = (k % 2 == 0); rand_resp();
      run_cycle();
      k++;
    end
    bus_if.respcyc = 1'b0;
    check_val("toggle_cycles", 64'(k), 64'(2 * BEATS - 1));
    check_val("toggle_beats", 64'(dbus_beats_seen), 64'(BEATS));
    check_val("toggle_owner", 64'(owner), 64'(2'b00));

    // Second tie goes back to ibus; reset lands at beat 4 of its read.
    ibus_if.reqcyc = 1'b1; ibus_if.reqtag = 13'h0042; dbus_if.reqcyc = 1'b1; dbus_if.reqtag = 13'h0077;
    run_cycle();
    check_val("rr_second_tie", 64'(owner), 64'(2'b01));
    ibus_if.reqcyc = 1'b0;
    run_cycle();
    acked_beats(4);
    bus_if.respcyc = 1'b1; rand_resp();
    reset = 1'b0;
    model_reset();
    #1;
    check_val("reset_abort_owner", 64'(owner), 64'(2'b00));
    check_val("reset_abort_resp", 64'(ibus_if.respcyc), 64'(1'b0));
    check_val("reset_abort_ack", 64'(bus_if.respack), 64'(1'b0));
    run_cycle();
    run_cycle();
    reset = 1'b1;
    ibus_if.reqcyc = 1'b0; bus_if.respcyc = 1'b0;
    run_cycle();
    check_val("post_reset_dbus", 64'(owner), 64'(2'b10));
    dbus_if.reqcyc = 1'b0;
    run_cycle();
    acked_beats(BEATS - 1);
    check_val("post_reset_not_done", 64'(owner), 64'(2'b10));
    acked_beats(1);
    check_val("post_reset_done", 64'(owner), 64'(2'b00));

    // Writes end without a response phase; a long dbus write locks ibus out.
    ibus_if.reqcyc = 1'b1; ibus_if.reqtag = 13'h1005;
    run_cycle();
    ibus_if.reqcyc = 1'b0;
    run_cycle();
    check_val("write_no_resp", 64'(owner), 64'(2'b00));
    ibus_if.reqcyc = 1'b1; ibus_if.reqtag = 13'h0010;
    dbus_if.reqcyc = 1'b1; dbus_if.reqtag = 13'h1abc;
    run_cycle();
    check_val("dbus_write_grant", 64'(owner), 64'(2'b10));
    for (int i = 0; i < 9; i++) begin
      dbus_if.req = {$urandom, $urandom};
      #1;
      check_val("ibus_locked_out", 64'(ibus_if.reqack), 64'(1'b0));
      run_cycle();
    end
    dbus_if.reqcyc = 1'b0;
    run_cycle();
    check_val("write_end_owner", 64'(owner), 64'(2'b00));
    run_cycle();
    check_val("ibus_after_write", 64'(owner), 64'(2'b01));
    ibus_if.reqcyc = 1'b0;
    run_cycle();
    acked_beats(BEATS);

    // Random traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      ibus_if.reqcyc  = ($urandom_range(0, 99) < 55);
      dbus_if.reqcyc  = ($urandom_range(0, 99) < 55);
      ibus_if.reqtag  = 13'($urandom);
      dbus_if.reqtag  = 13'($urandom);
      ibus_if.req     = {$urandom, $urandom};
      dbus_if.req     = {$urandom, $urandom};
      ibus_if.respack = ($urandom_range(0, 99) < 70);
      dbus_if.respack = ($urandom_range(0, 99) < 70);
      bus_if.reqack   = 1'($urandom);
      bus_if.respcyc  = ($urandom_range(0, 99) < 75);
      rand_resp();
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        model_reset();
        run_cycle();
        run_cycle();
        reset = 1'b1;
      end
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sysbus_txn_arbiter.md
SYSBUS_TXN_ARBITER -- requirements
Module: sysbus_txn_arbiter

Interface
REQ-001 Parameter BUS_DATA_WIDTH SHALL default to 64; it sets the data width of the shared bus and both client ports.
REQ-002 Parameter BUS_TAG_WIDTH SHALL default to 13; it sets the tag width of the shared bus and both client ports.
REQ-003 Parameter RESP_BEATS SHALL default to 8; it sets the number of response beats per read transaction, legal range 1-255.
REQ-004 Parameter WR_TAG_BIT SHALL default to 12; it is the reqtag bit index that marks a write (1 = write, 0 = read).
REQ-005 clk  in  1  clock; the block SHALL use this single clock domain.
REQ-006 reset  in  1  reset; asynchronous, active-low.
REQ-007 bus_req/bus_reqcyc/bus_reqtag  out  BUS_DATA_WIDTH/1/BUS_TAG_WIDTH  shared-bus request.
REQ-008 bus_reqack  in  1  shared-bus request accept.
REQ-009 bus_resp/bus_respcyc/bus_resptag  in  BUS_DATA_WIDTH/1/BUS_TAG_WIDTH  shared-bus response.
REQ-010 bus_respack  out  1  shared-bus response accept.
REQ-011 ibus_req/ibus_reqcyc/ibus_reqtag/ibus_respack  in  widths as bus  fetch-client request and response accept.
REQ-012 ibus_reqack/ibus_respcyc/ibus_resp/ibus_resptag  out  widths as bus  fetch-client accept and response.
REQ-013 dbus_* ports SHALL mirror the ibus_* ports for the data client.
REQ-014 owner  out  2  current grant: 00 none, 01 ibus, 10 dbus.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, REQ and RESP.
REQ-016 IDLE: on any reqcyc sampled high, the FSM SHALL move to REQ, register owner, and latch is_write = owner reqtag[WR_TAG_BIT].
REQ-017 Arbitration SHALL be round-robin: with both clients requesting, grant the client not granted last; otherwise grant the single requester.
REQ-018 Grant latency SHALL be 1 cycle: bus_reqcyc is asserted in the first REQ cycle, never in IDLE.
REQ-019 REQ: bus_req/bus_reqcyc/bus_reqtag SHALL pass combinationally from the owner; the owner reqack SHALL equal bus_reqack; the non-owner reqack SHALL be 0.
REQ-020 REQ exit: when the owner reqcyc is sampled low, the FSM SHALL go to IDLE if is_write, otherwise to RESP with beat counter = 0.
REQ-021 The grant SHALL be held through multi-beat write requests; the non-owner SHALL be ignored until return to IDLE.
REQ-022 RESP: bus_resp/bus_respcyc/bus_resptag SHALL route to the owner only; bus_respack SHALL equal the owner respack.
REQ-023 RESP: the non-owner respcyc/resp/resptag SHALL be 0, and bus_reqcyc SHALL be 0.
REQ-024 A beat SHALL be counted on bus_respcyc && bus_respack.
REQ-025 On the beat at which the counter equals RESP_BEATS-1, the FSM SHALL return to IDLE at the next edge and clear the counter.
REQ-026 The counter SHALL be 8 bits wide and SHALL never exceed RESP_BEATS-1.
REQ-027 bus_respcyc asserted in IDLE or REQ SHALL be dropped: no client respcyc, and bus_respack = 0.
REQ-028 Back-to-back: a new grant SHALL be possible in the cycle after return to IDLE, i.e. a minimum 1 idle cycle between transactions.
REQ-029 All outputs not driven by the active state SHALL be 0; no latches, and every comb output SHALL be defaulted.

Reset
REQ-030 While reset is low: state = IDLE, owner = 00, beat counter = 0, is_write = 0, last-granted = dbus (so ibus wins the first tie).
REQ-031 While reset is low: all bus_* outputs and all client outputs SHALL be 0.
REQ-032 Reset asserted mid-REQ or mid-RESP SHALL abort the transaction immediately; no partial-grant state survives.

Verification
REQ-033 ibus read (reqtag[12]=0) held 1 cycle plus 8 acked resp beats -> bus_reqcyc high 1 cycle after ibus_reqcyc; ibus receives all 8 beats with matching resptag; owner returns to 00 after beat 8; dbus_respcyc stays 0.
REQ-034 ibus and dbus assert reqcyc in the same cycle from reset -> ibus granted first; after ibus completes, dbus granted next; a second simultaneous request then grants ibus.
REQ-035 dbus write (reqtag[12]=1), reqcyc held 9 cycles with ibus requesting throughout -> ibus_reqack = 0 for all 9 cycles; FSM goes to IDLE with no RESP; ibus granted next.
REQ-036 Response beats with respack toggling 1,0,1,... -> counter advances only on acked beats; transaction ends after exactly 8 acked beats.
REQ-037 Reset pulled low at beat 4 of an ibus read -> all outputs 0 asynchronously; after release, a new dbus request is granted with counter starting at 0.
REQ-038 Stray bus_respcyc in IDLE -> no client respcyc, and bus_respack = 0.
